// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch/memory-access client handshakes and the shared memory port.
// The arbiter takes the master view; the environment (clients and memory) takes the slave view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ma_req;
  logic        ma_we;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        if_done;
  logic [31:0] if_rdata;
  logic        ma_done;
  logic [31:0] ma_rdata;
  logic        halt;
  logic        bus_err;

  modport master (
    input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, if_done, if_rdata, ma_done, ma_rdata,
           halt, bus_err
  );

  modport slave (
    output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, if_done, if_rdata, ma_done, ma_rdata,
           halt, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the memory-access stage.
// Memory access wins ties; a stalled transaction is aborted after TIMEOUT cycles with a sticky bus_err.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_MA,
    GRANT_IF,
    DONE
  } state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_done_q, if_done_d;
  logic        ma_done_q, ma_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ma_rdata_q, ma_rdata_d;
  logic        bus_err_q, bus_err_d;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    ma_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ma_rdata_d  = ma_rdata_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      IDLE: begin
        if (bus.ma_req) begin
          state_d     = GRANT_MA;
          wait_cnt_d  = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ma_we;
          mem_addr_d  = bus.ma_addr;
          mem_wdata_d = bus.ma_wdata;
        end else if (bus.if_req) begin
          state_d     = GRANT_IF;
          wait_cnt_d  = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'd0;
        end
      end

      // An ack on the last wait cycle still wins over the timeout abort.
      GRANT_MA: begin
        if (bus.mem_ack) begin
          if (!mem_we_q) begin
            ma_rdata_d = bus.mem_rdata;
          end
          ma_done_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (wait_cnt_q == WaitLast) begin
          bus_err_d = 1'b1;
          ma_done_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      GRANT_IF: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          if_done_d  = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = DONE;
        end else if (wait_cnt_q == WaitLast) begin
          bus_err_d = 1'b1;
          if_done_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      ma_done_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      ma_rdata_q  <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      ma_done_q   <= ma_done_d;
      if_rdata_q  <= if_rdata_d;
      ma_rdata_q  <= ma_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.ma_done   = ma_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ma_rdata  = ma_rdata_q;
  assign bus.bus_err   = bus_err_q;

  // Stall a client until the cycle its completion pulse is visible.
  assign bus.halt = (bus.ma_req & ~ma_done_q) | (bus.if_req & ~if_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized clients/memory compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = port free, 1 = transaction outstanding, 2 = cool-down cycle.
  int          mPhase;
  int          mOwner;
  int          mGrantCycles;
  logic        mMemReq, mMemWe;
  logic [31:0] mMemAddr, mMemWdata, mIfRdata, mMaRdata;
  logic        mIfDone, mMaDone, mBusErr;
  bit          modelValid = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      mPhase <= 0; mOwner <= 0; mGrantCycles <= 0;
      mMemReq <= 1'b0; mMemWe <= 1'b0; mMemAddr <= '0; mMemWdata <= '0;
      mIfRdata <= '0; mMaRdata <= '0; mIfDone <= 1'b0; mMaDone <= 1'b0; mBusErr <= 1'b0;
      modelValid <= 1'b1;
    end else begin
      mIfDone <= 1'b0;
      mMaDone <= 1'b0;
      if (mPhase == 0) begin
        if (bus.ma_req) begin
          mPhase <= 1; mOwner <= 1; mGrantCycles <= 1; mMemReq <= 1'b1;
          mMemWe <= bus.ma_we; mMemAddr <= bus.ma_addr; mMemWdata <= bus.ma_wdata;
        end else if (bus.if_req) begin
          mPhase <= 1; mOwner <= 2; mGrantCycles <= 1; mMemReq <= 1'b1;
          mMemWe <= 1'b0; mMemAddr <= bus.if_addr; mMemWdata <= '0;
        end
      end else if (mPhase == 1) begin
        if (bus.mem_ack || mGrantCycles == TIMEOUT) begin
          mPhase  <= 2;
          mMemReq <= 1'b0;
          if (mOwner == 1) mMaDone <= 1'b1;
          else             mIfDone <= 1'b1;
          if (!bus.mem_ack)                 mBusErr  <= 1'b1;
          else if (mOwner == 2)             mIfRdata <= bus.mem_rdata;
          else if (!mMemWe)                 mMaRdata <= bus.mem_rdata;
        end else begin
          mGrantCycles <= mGrantCycles + 1;
        end
      end else begin
        mPhase <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkOutput(name, 32'(actual), 32'(expected));
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkFlag("mem_req", bus.mem_req, mMemReq);
      if (mMemReq) begin
        checkFlag("mem_we", bus.mem_we, mMemWe);
        checkOutput("mem_addr", bus.mem_addr, mMemAddr);
        checkOutput("mem_wdata", bus.mem_wdata, mMemWdata);
      end
      checkFlag("if_done", bus.if_done, mIfDone);
      checkFlag("ma_done", bus.ma_done, mMaDone);
      checkOutput("if_rdata", bus.if_rdata, mIfRdata);
      checkOutput("ma_rdata", bus.ma_rdata, mMaRdata);
      checkFlag("bus_err", bus.bus_err, mBusErr);
      checkFlag("halt", bus.halt, (bus.ma_req & ~mMaDone) | (bus.if_req & ~mIfDone));
      checkFlag("done_exclusive", bus.if_done & bus.ma_done, 1'b0);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus();
    if (!reset) reset = 1'b1;
    else if ($urandom_range(0, 299) == 0) reset = 1'b0;

    if (!bus.ma_req) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.ma_req   = 1'b1;
        bus.ma_we    = 1'($urandom_range(0, 1));
        bus.ma_addr  = $urandom & 32'hFFFF_FFFC;
        bus.ma_wdata = $urandom;
      end
    end else if (mMaDone || $urandom_range(0, 39) == 0) begin
      bus.ma_req = 1'b0;
    end

    if (!bus.if_req) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
    end else if (mIfDone || $urandom_range(0, 39) == 0) begin
      bus.if_req = 1'b0;
    end

    bus.mem_rdata = $urandom;
    if (mMemReq) bus.mem_ack = ($urandom_range(0, 4) == 0);
    else         bus.mem_ack = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    int  highCnt;
    bit  sawDone;

    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ma_req = 1'b0; bus.ma_we = 1'b0; bus.ma_addr = '0; bus.ma_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    nextCycle();
    nextCycle();
    checkFlag("rst_mem_req", bus.mem_req, 1'b0);
    checkFlag("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
    checkFlag("rst_bus_err", bus.bus_err, 1'b0);
    reset = 1'b1;

    // Fetch completing on its third memory-request cycle.
    nextCycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    nextCycle();
    checkFlag("f_mem_req", bus.mem_req, 1'b1);
    checkOutput("f_mem_addr", bus.mem_addr, 32'h100);
    checkFlag("f_mem_we", bus.mem_we, 1'b0);
    checkFlag("f_halt", bus.halt, 1'b1);
    nextCycle();
    nextCycle();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2400_0001;
    nextCycle();
    checkFlag("f_if_done", bus.if_done, 1'b1);
    checkOutput("f_if_rdata", bus.if_rdata, 32'h2400_0001);
    checkOutput("f_model_if_rdata", mIfRdata, 32'h2400_0001);
    checkFlag("f_halt_done", bus.halt, 1'b0);
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    nextCycle();
    checkFlag("f_if_done_once", bus.if_done, 1'b0);

    // Simultaneous store and fetch: store first, then fetch after the cool-down.
    bus.ma_req = 1'b1; bus.ma_we = 1'b1; bus.ma_addr = 32'h40; bus.ma_wdata = 32'hDEAD_BEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    nextCycle();
    checkFlag("s_mem_we", bus.mem_we, 1'b1);
    checkOutput("s_mem_addr", bus.mem_addr, 32'h40);
    checkOutput("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
    nextCycle();
    checkFlag("s_ma_done", bus.ma_done, 1'b1);
    checkOutput("s_ma_rdata_kept", bus.ma_rdata, 32'h0);
    checkFlag("s_mem_req_low", bus.mem_req, 1'b0);
    bus.mem_ack = 1'b0; bus.ma_req = 1'b0;
    nextCycle();
    checkFlag("s_idle_gap", bus.mem_req, 1'b0);
    nextCycle();
    checkFlag("s_if_granted", bus.mem_req, 1'b1);
    checkOutput("s_if_addr", bus.mem_addr, 32'h200);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_1234;
    nextCycle();
    checkFlag("s_if_done", bus.if_done, 1'b1);
    checkOutput("s_if_rdata", bus.if_rdata, 32'h0000_1234);
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    nextCycle();

    // Load with no ack at all must time out.
    bus.ma_req = 1'b1; bus.ma_we = 1'b0; bus.ma_addr = 32'h80;
    highCnt = 0; sawDone = 1'b0;
    for (int i = 0; i < 40 && !sawDone; i++) begin
      nextCycle();
      if (bus.mem_req) highCnt++;
      if (bus.ma_done) sawDone = 1'b1;
    end
    checkOutput("t_req_cycles", 32'(highCnt), 32'd16);
    checkFlag("t_ma_done", 1'(sawDone), 1'b1);
    checkFlag("t_bus_err", bus.bus_err, 1'b1);
    checkFlag("t_model_bus_err", mBusErr, 1'b1);
    checkOutput("t_ma_rdata_kept", bus.ma_rdata, 32'h0);
    bus.ma_req = 1'b0;
    repeat (3) nextCycle();
    checkFlag("t_bus_err_sticky", bus.bus_err, 1'b1);

    // Ack on the sixteenth wait cycle completes normally.
    reset = 1'b0;
    nextCycle();
    checkFlag("r_bus_err_clear", bus.bus_err, 1'b0);
    reset = 1'b1;
    bus.ma_req = 1'b1; bus.ma_we = 1'b0; bus.ma_addr = 32'h84;
    nextCycle();
    repeat (15) nextCycle();
    checkFlag("l_last_wait_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    nextCycle();
    checkFlag("l_ma_done", bus.ma_done, 1'b1);
    checkOutput("l_ma_rdata", bus.ma_rdata, 32'hCAFE_F00D);
    checkFlag("l_no_bus_err", bus.bus_err, 1'b0);
    bus.mem_ack = 1'b0; bus.ma_req = 1'b0;
    nextCycle();

    // Reset in the middle of a fetch wait abandons it.
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    nextCycle();
    checkFlag("x_mem_req", bus.mem_req, 1'b0);
    checkFlag("x_if_done", bus.if_done, 1'b0);
    checkOutput("x_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("x_ma_rdata", bus.ma_rdata, 32'h0);
    reset = 1'b1;
    nextCycle();
    checkFlag("x_regrant", bus.mem_req, 1'b1);
    checkOutput("x_regrant_addr", bus.mem_addr, 32'h300);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0777;
    nextCycle();
    checkFlag("x_if_done", bus.if_done, 1'b1);
    checkOutput("x_if_rdata", bus.if_rdata, 32'h0000_0777);
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    repeat (2) nextCycle();

    // Spurious ack with the port idle is ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    nextCycle();
    checkFlag("i_if_done", bus.if_done, 1'b0);
    checkFlag("i_ma_done", bus.ma_done, 1'b0);
    checkOutput("i_if_rdata", bus.if_rdata, 32'h0000_0777);
    checkFlag("i_mem_req", bus.mem_req, 1'b0);
    bus.mem_ack = 1'b0;
    nextCycle();

    for (int c = 0; c < 2500; c++) begin
      nextCycle();
      applyStimulus();
    end
    repeat (2) nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
